// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default sizing, car state encoding and direction codes.
// Reused by the central control unit and every car controller.
package elevator_pkg;

   localparam int unsigned NUM_FLOORS_DFLT = 10;
   localparam int unsigned FLOOR_W_DFLT    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } car_state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/car_timer.sv
// Loadable down-counter shared by the travel and door phases of a car.
// Load has priority over decrement; the count saturates at zero.
module car_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Per-car motion/door sequencer driven by the CCU's floors_to_visit mask.
// Define CAR_ESTOP_EN to add the estop input (freezes travel, holds door, blocks departures).
module elevator_car_ctrl
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS    = NUM_FLOORS_DFLT,
   parameter int unsigned FLOOR_W       = FLOOR_W_DFLT,
   parameter int unsigned TRAVEL_CYCLES = 8,
   parameter int unsigned DOOR_CYCLES   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef CAR_ESTOP_EN
   input  logic                  estop,
`endif
   input  logic [NUM_FLOORS-1:0] floors_to_visit,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  direction,
   output logic                  idle,
   output logic                  moving,
   output logic                  door_open,
   output logic                  served_valid,
   output logic [FLOOR_W-1:0]    served_floor
);

   localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [TimerW-1:0] TravelLoad = TimerW'(TRAVEL_CYCLES - 1);
   localparam logic [TimerW-1:0] DoorLoad   = TimerW'(DOOR_CYCLES - 1);

   logic estop_act;
`ifdef CAR_ESTOP_EN
   assign estop_act = estop;
`else
   assign estop_act = 1'b0;
`endif

   function automatic logic req_at(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (m[i] && (i == int'(f))) r = 1'b1;
      end
      return r;
   endfunction

   // Any request strictly beyond floor f in the given direction.
   function automatic logic req_beyond(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f,
                                       input logic up);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (m[i] && (up ? (i > int'(f)) : (i < int'(f)))) r = 1'b1;
      end
      return r;
   endfunction

   car_state_e          state_q, state_d;
   logic [FLOOR_W-1:0]  floor_q, floor_d;
   logic                dir_q, dir_d;
   logic                served_valid_q, served_valid_d;
   logic [FLOOR_W-1:0]  served_floor_q, served_floor_d;
   logic [FLOOR_W-1:0]  next_floor;
   logic                req_up, req_down;
   logic                t_load, t_en, t_zero;
   logic [TimerW-1:0]   t_load_val;

   car_timer #(
      .WIDTH (TimerW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (t_load),
      .load_val_i (t_load_val),
      .en_i       (t_en),
      .zero_o     (t_zero)
   );

   assign req_up   = req_beyond(floors_to_visit, floor_q, DIR_UP);
   assign req_down = req_beyond(floors_to_visit, floor_q, DIR_DOWN);

   always_comb begin
      state_d        = state_q;
      floor_d        = floor_q;
      dir_d          = dir_q;
      served_valid_d = 1'b0;
      served_floor_d = served_floor_q;
      t_load         = 1'b0;
      t_load_val     = TravelLoad;
      t_en           = 1'b0;
      next_floor     = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (!estop_act) begin
               if (req_at(floors_to_visit, floor_q)) begin
                  state_d        = ST_DOOR;
                  t_load         = 1'b1;
                  t_load_val     = DoorLoad;
                  served_valid_d = 1'b1;
                  served_floor_d = floor_q;
               end else if (req_up || req_down) begin
                  // With requests on both sides the current direction is kept.
                  if (!(req_up && req_down)) dir_d = req_up ? DIR_UP : DIR_DOWN;
                  state_d = ST_MOVE;
                  t_load  = 1'b1;
               end
            end
         end
         ST_MOVE: begin
            if (!estop_act) begin
               if (t_zero) begin
                  floor_d = next_floor;
                  if (req_at(floors_to_visit, next_floor)) begin
                     state_d        = ST_DOOR;
                     t_load         = 1'b1;
                     t_load_val     = DoorLoad;
                     served_valid_d = 1'b1;
                     served_floor_d = next_floor;
                  end else if (req_beyond(floors_to_visit, next_floor, dir_q)) begin
                     t_load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  t_en = 1'b1;
               end
            end
         end
         ST_DOOR: begin
            if (estop_act) begin
               t_load     = 1'b1;
               t_load_val = DoorLoad;
            end else if (t_zero) begin
               state_d = ST_IDLE;
            end else begin
               t_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         floor_q        <= '0;
         dir_q          <= DIR_UP;
         served_valid_q <= 1'b0;
         served_floor_q <= '0;
      end else begin
         state_q        <= state_d;
         floor_q        <= floor_d;
         dir_q          <= dir_d;
         served_valid_q <= served_valid_d;
         served_floor_q <= served_floor_d;
      end
   end

   assign current_floor = floor_q;
   assign direction     = dir_q;
   assign idle          = (state_q == ST_IDLE);
   assign moving        = (state_q == ST_MOVE) && !estop_act;
   assign door_open     = (state_q == ST_DOOR);
   assign served_valid  = served_valid_q;
   assign served_floor  = served_floor_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with default sizing (10 floors, 8 travel, 16 door cycles).
// Define CAR_ESTOP_EN to also exercise the emergency stop.
module tb_elevator_car_ctrl;

   localparam int NF = 10;
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NF-1:0] mask;
   logic [FW-1:0] current_floor;
   logic          direction, idle, moving, door_open, served_valid;
   logic [FW-1:0] served_floor;
`ifdef CAR_ESTOP_EN
   logic          estop;
`endif

   int checks = 0;
   int errors = 0;

   elevator_car_ctrl #(
      .NUM_FLOORS    (NF),
      .FLOOR_W       (FW),
      .TRAVEL_CYCLES (8),
      .DOOR_CYCLES   (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
`ifdef CAR_ESTOP_EN
      .estop           (estop),
`endif
      .floors_to_visit (mask),
      .current_floor   (current_floor),
      .direction       (direction),
      .idle            (idle),
      .moving          (moving),
      .door_open       (door_open),
      .served_valid    (served_valid),
      .served_floor    (served_floor)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_sv(input int limit, output int n);
      n = 0;
      while (!served_valid && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_idle(input int limit, output int n);
      n = 0;
      while (!idle && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_floor(input logic [FW-1:0] f, input int limit, output int n);
      n = 0;
      while (current_floor != f && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      mask = '0;
      ticks(2);
      checks++; if (current_floor !== 4'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", current_floor); end
      checks++; if (direction !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b expected 1", direction); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
      checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %b expected 0", moving); end
      checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door: got %b expected 0", door_open); end
      checks++; if (served_valid !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b expected 0", served_valid); end
      checks++; if (served_floor !== 4'd0) begin errors++; $display("FAIL reset_sf: got %0d expected 0", served_floor); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_same_floor();
      mask = 10'h001;
      tick();
      checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL same_door: got %b expected 1", door_open); end
      checks++; if (served_valid !== 1'b1) begin errors++; $display("FAIL same_sv: got %b expected 1", served_valid); end
      checks++; if (served_floor !== 4'd0) begin errors++; $display("FAIL same_sf: got %0d expected 0", served_floor); end
      checks++; if (moving !== 1'b0 || current_floor !== 4'd0) begin errors++; $display("FAIL same_nomove: got moving=%b floor=%0d expected 0/0", moving, current_floor); end
      mask = '0;
      tick();
      checks++; if (served_valid !== 1'b0 || door_open !== 1'b1) begin errors++; $display("FAIL same_pulse: got sv=%b door=%b expected 0/1", served_valid, door_open); end
      ticks(14);
      checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL same_door_last: got %b expected 1", door_open); end
      tick();
      checks++; if (idle !== 1'b1 || door_open !== 1'b0) begin errors++; $display("FAIL same_door_close: got idle=%b door=%b expected 1/0", idle, door_open); end
   endtask

   task automatic test_up_to_5();
      mask = 10'h020;
      tick();
      checks++; if (moving !== 1'b1 || direction !== 1'b1) begin errors++; $display("FAIL up5_start: got moving=%b dir=%b expected 1/1", moving, direction); end
      ticks(8);
      checks++; if (current_floor !== 4'd1) begin errors++; $display("FAIL up5_floor1: got %0d expected 1", current_floor); end
      ticks(31);
      checks++; if (current_floor !== 4'd4 || door_open !== 1'b0) begin errors++; $display("FAIL up5_floor4: got floor=%0d door=%b expected 4/0", current_floor, door_open); end
      tick();
      checks++; if (current_floor !== 4'd5 || door_open !== 1'b1) begin errors++; $display("FAIL up5_arrive: got floor=%0d door=%b expected 5/1", current_floor, door_open); end
      checks++; if (served_valid !== 1'b1 || served_floor !== 4'd5) begin errors++; $display("FAIL up5_served: got sv=%b sf=%0d expected 1/5", served_valid, served_floor); end
      mask = '0;
      tick();
      checks++; if (served_valid !== 1'b0) begin errors++; $display("FAIL up5_pulse: got %b expected 0", served_valid); end
      ticks(14);
      checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL up5_door_last: got %b expected 1", door_open); end
      tick();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL up5_idle: got %b expected 1", idle); end
   endtask

   task automatic test_keep_down();
      int n;
      mask = 10'h010;
      tick();
      checks++; if (direction !== 1'b0 || moving !== 1'b1) begin errors++; $display("FAIL down4_start: got dir=%b moving=%b expected 0/1", direction, moving); end
      wait_sv(20, n);
      checks++; if (n !== 8 || served_floor !== 4'd4) begin errors++; $display("FAIL down4_arrive: got %0d cycles sf=%0d expected 8/4", n, served_floor); end
      mask = '0;
      wait_idle(30, n);
      checks++; if (n !== 16) begin errors++; $display("FAIL down4_door: got %0d cycles expected 16", n); end
      mask = 10'h201;
      tick();
      checks++; if (direction !== 1'b0 || moving !== 1'b1) begin errors++; $display("FAIL both_keep_dir: got dir=%b moving=%b expected 0/1", direction, moving); end
      wait_sv(60, n);
      checks++; if (n !== 32 || served_floor !== 4'd0 || current_floor !== 4'd0) begin errors++; $display("FAIL both_floor0_first: got %0d cycles sf=%0d floor=%0d expected 32/0/0", n, served_floor, current_floor); end
      mask = 10'h200;
      wait_idle(30, n);
      checks++; if (n !== 16) begin errors++; $display("FAIL both_door: got %0d cycles expected 16", n); end
   endtask

   task automatic test_clear_mid();
      int  n;
      logic seen;
      tick();
      checks++; if (direction !== 1'b1 || moving !== 1'b1) begin errors++; $display("FAIL clr_start: got dir=%b moving=%b expected 1/1", direction, moving); end
      wait_floor(4'd6, 60, n);
      checks++; if (n !== 48) begin errors++; $display("FAIL clr_floor6: got %0d cycles expected 48", n); end
      mask = '0;
      n    = 0;
      seen = 1'b0;
      while (!idle && n < 20) begin
         tick();
         n++;
         if (door_open || served_valid) seen = 1'b1;
      end
      checks++; if (n !== 8 || current_floor !== 4'd7) begin errors++; $display("FAIL clr_idle7: got %0d cycles floor=%0d expected 8/7", n, current_floor); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clr_nodoor: got door/served seen=%b expected 0", seen); end
   endtask

   task automatic test_reset_mid_move();
      int n;
      mask = 10'h001;
      tick();
      wait_floor(4'd3, 40, n);
      checks++; if (n !== 32 || moving !== 1'b1) begin errors++; $display("FAIL rstmv_floor3: got %0d cycles moving=%b expected 32/1", n, moving); end
      ticks(3);
      rst = 1'b1;
      tick();
      checks++; if (current_floor !== 4'd0 || idle !== 1'b1) begin errors++; $display("FAIL rstmv_state: got floor=%0d idle=%b expected 0/1", current_floor, idle); end
      checks++; if (moving !== 1'b0 || door_open !== 1'b0 || direction !== 1'b1) begin errors++; $display("FAIL rstmv_outs: got moving=%b door=%b dir=%b expected 0/0/1", moving, door_open, direction); end
      mask = '0;
      rst  = 1'b0;
      tick();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmv_stay: got idle=%b expected 1", idle); end
   endtask

`ifdef CAR_ESTOP_EN
   task automatic test_estop();
      int n;
      mask = 10'h004;
      tick();
      ticks(3);
      estop = 1'b1;
      tick();
      checks++; if (moving !== 1'b0) begin errors++; $display("FAIL estop_moving: got %b expected 0", moving); end
      ticks(19);
      checks++; if (current_floor !== 4'd0) begin errors++; $display("FAIL estop_hold: got floor=%0d expected 0", current_floor); end
      estop = 1'b0;
      wait_sv(40, n);
      checks++; if (n !== 13 || served_floor !== 4'd2) begin errors++; $display("FAIL estop_delay: got %0d cycles sf=%0d expected 13/2", n, served_floor); end
      mask  = '0;
      estop = 1'b1;
      ticks(30);
      checks++; if (door_open !== 1'b1 || served_valid !== 1'b0) begin errors++; $display("FAIL estop_door_hold: got door=%b sv=%b expected 1/0", door_open, served_valid); end
      estop = 1'b0;
      wait_idle(40, n);
      checks++; if (n !== 16) begin errors++; $display("FAIL estop_door_release: got %0d cycles expected 16", n); end
   endtask
`endif

   initial begin
      rst  = 1'b1;
      mask = '0;
`ifdef CAR_ESTOP_EN
      estop = 1'b0;
`endif
      test_reset();
      test_same_floor();
      test_up_to_5();
      test_keep_down();
      test_clear_mid();
      test_reset_mid_move();
`ifdef CAR_ESTOP_EN
      test_estop();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
